cbus_arbiter: RTL and testbench
===============================

Name: cbus_arbiter

Overview:
Sits between the core's per-port bus adapters (instruction-side and data-side converters, each emitting one cbus request) and the single cbus memory port that feeds the RAM model. It grants exactly one master at a time and forwards that master's request to the single output port. It routes the responses back to that master, and holds the grant until the final beat of the burst completes. Arbitration policy is fixed-priority or round-robin, selected by parameter.

Parameters:
NUM_INPUTS, 2, number of cbus masters; 1..8 (index 0 = instruction side, 1 = data side).
ROUND_ROBIN, 0, 0 = fixed priority (lowest index wins); 1 = round-robin rotating pointer.

Ports:
clk  input  1  sole clock.
reset  input  1  asynchronous, active-high reset.
ireqs  input  NUM_INPUTS x cbus_req_t  master requests (valid, is_write, size, addr, strobe, data, len, burst).
iresps  output  NUM_INPUTS x cbus_resp_t  per-master responses (ready, last, data).
oreq  output  cbus_req_t  request to memory side.
oresp  input  cbus_resp_t  memory-side response.

Interface note: one clock; reset is asynchronous and active-high.

Behaviour:
- State register: IDLE / BUSY, plus index register sel of width clog2(NUM_INPUTS) (min 1).
- Round-robin mode adds pointer ptr of the same width.
- Reset (async, any cycle): state=IDLE, sel=0, ptr=0. oreq all-zero (valid=0). All iresps all-zero.
- IDLE:
  - Choose the winner among masters with ireqs[i].valid=1.
  - Fixed mode: the lowest valid index wins.
  - Round-robin mode: first valid index scanning ptr, ptr+1, ... with modulo-NUM_INPUTS wrap.
  - If any master is valid: sel<=winner, state<=BUSY.
  - In IDLE, oreq.valid=0 and all iresps are zero. There is no combinational path from ireqs to oreq in IDLE.
- BUSY:
  - oreq = ireqs[sel] (combinational forward).
  - iresps[sel] = oresp. All other iresps are zero.
- Completion: on a cycle in BUSY with oresp.ready=1 and oresp.last=1, state<=IDLE.
  - Round-robin mode also sets ptr<=sel+1 (wraps).
  - Fixed mode leaves ptr unchanged.
- Latency:
  - A request valid at edge N is seen on oreq from cycle N+1.
  - After the last beat, there is one IDLE cycle before the next grant. Minimum gap between back-to-back transactions is 1 cycle.
- Bursts: beats with ready=1, last=0 do not release the grant, for any len (0..15).
- Masters must hold valid and all request fields stable until their last beat. Behaviour if a granted master drops valid early:
  - oreq.valid follows it low.
  - The grant is still held until ready&&last.
- oresp.ready while IDLE is ignored; state is unchanged.
- Requests arriving during BUSY from other masters see ready=0 until they are granted. There is no starvation in round-robin mode.
- NUM_INPUTS=1: degenerates to a registered pass-through with the same IDLE/BUSY timing.

Test Plan:
- Single read, master 1, addr=0x8000_0000, len=0; memory answers ready=1, last=1, data=0xDEAD_BEEF after 2 cycles -> oreq.valid rises the cycle after ireqs[1].valid. iresps[1] gets the data. iresps[0] stays 0. Arbiter returns to IDLE.
- Fixed priority: masters 0 and 1 assert valid in the same cycle -> master 0 is served first. Master 1 is granted exactly 1 idle cycle after master 0's last beat.
- Round-robin: both masters continuously valid, 4 single-beat transactions -> grant order 0,1,0,1.
- Burst write from master 1, len=3 (4 beats, last on beat 4), master 0 valid throughout -> grant stays on master 1 through all 4 beats. Master 0 sees ready=0 until then.
- Reset asserted mid-burst (after beat 2 of 4) -> on that edge oreq.valid=0, all iresps are 0, and state is IDLE. After reset release, the still-valid master is re-granted 1 cycle later.
- Spurious oresp.ready=1 while IDLE and no master valid -> no state change. oreq.valid stays 0.

Source files
------------

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: grants one cbus master at a time (fixed priority or round-robin)
// and holds the grant until the final response beat of its burst.
package cbus_pkg;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;
    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;
endpackage

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_INPUTS  = 2,
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  cbus_req_t  [NUM_INPUTS-1:0] ireqs,
    output cbus_resp_t [NUM_INPUTS-1:0] iresps,
    output cbus_req_t                   oreq,
    input  cbus_resp_t                  oresp
);
    localparam int SW = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1;
    typedef enum logic {IDLE, BUSY} state_t;
    state_t r_state, w_state_nxt;
    logic [SW-1:0] r_sel, r_ptr, w_sel_nxt, w_ptr_nxt, w_base, w_idx, w_winner, w_sel_inc;
    logic w_any, w_done;
    assign w_base    = ROUND_ROBIN ? r_ptr : '0;
    assign w_done    = r_state == BUSY && oresp.ready && oresp.last;
    assign w_sel_inc = r_sel == SW'(NUM_INPUTS - 1) ? '0 : r_sel + 1'b1;
    // Scan from the base downwards so the entry closest to the base wins.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            w_idx = SW'((int'(w_base) + k) % NUM_INPUTS);
            if (ireqs[w_idx].valid) begin
                w_any    = 1'b1;
                w_winner = w_idx;
            end
        end
    end
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        if (r_state == IDLE && w_any) begin
            w_state_nxt = BUSY;
            w_sel_nxt   = w_winner;
        end else if (w_done) begin
            w_state_nxt = IDLE;
            w_ptr_nxt   = ROUND_ROBIN ? w_sel_inc : r_ptr;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end
    assign oreq = r_state == BUSY ? ireqs[r_sel] : '0;
    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_resp
        assign iresps[g] = (r_state == BUSY && r_sel == SW'(g)) ? oresp : '0;
    end
endmodule

// File: tb/tb_cbus_arbiter.sv
// tb_cbus_arbiter: random masters and memory responder driving a fixed-priority
// and a round-robin arbiter, checked every cycle against a transaction-level model.
module tb_cbus_arbiter;
    import cbus_pkg::*;
    localparam int N = 3;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    cbus_req_t  [N-1:0] ireqs  [2];
    cbus_resp_t [N-1:0] iresps [2];
    cbus_req_t          oreq   [2];
    cbus_resp_t         oresp  [2];
    cbus_arbiter #(.NUM_INPUTS(N), .ROUND_ROBIN(1'b0)) u_fix (
        .clk(clk), .reset(reset), .ireqs(ireqs[0]), .iresps(iresps[0]),
        .oreq(oreq[0]), .oresp(oresp[0])
    );
    cbus_arbiter #(.NUM_INPUTS(N), .ROUND_ROBIN(1'b1)) u_rr (
        .clk(clk), .reset(reset), .ireqs(ireqs[1]), .iresps(iresps[1]),
        .oreq(oreq[1]), .oresp(oresp[1])
    );
    // Model: who owns each port, how far through its burst, and where round-robin resumes.
    bit busy [2];
    int owner [2], beats [2], olen [2], next_first [2];
    bit pend [2][N];
    int vectors = 0, errors = 0;
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic int pick(input int d);
        int base = d == 0 ? 0 : next_first[d];
        for (int k = 0; k < N; k++)
            if (ireqs[d][(base + k) % N].valid) return (base + k) % N;
        return -1;
    endfunction
    function automatic cbus_req_t rand_req();
        cbus_req_t r;
        r.valid    = 1'b1;
        r.is_write = 1'($urandom);
        r.size     = 2'($urandom);
        r.addr     = $urandom;
        r.strobe   = 4'($urandom);
        r.data     = $urandom;
        r.len      = 4'($urandom_range(0, 5));
        r.burst    = 2'($urandom);
        return r;
    endfunction
    task automatic check_all(input string ph);
        cbus_req_t er;
        cbus_resp_t [N-1:0] es;
        for (int d = 0; d < 2; d++) begin
            er = busy[d] ? ireqs[d][owner[d]] : '0;
            es = '0;
            if (busy[d]) es[owner[d]] = oresp[d];
            chk($sformatf("%s_oreq%0d", ph, d), 128'(oreq[d]), 128'(er));
            chk($sformatf("%s_iresps%0d", ph, d), 128'(iresps[d]), 128'(es));
        end
    endtask
    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            busy[d] = 1'b0;
            next_first[d] = 0;
            for (int i = 0; i < N; i++)
                if (pend[d][i] && !ireqs[d][i].valid) pend[d][i] = 1'b0;
        end
    endtask
    initial begin
        for (int d = 0; d < 2; d++) begin
            ireqs[d] = '0;
            oresp[d] = '0;
            owner[d] = 0;
            beats[d] = 0;
            olen[d]  = 0;
            for (int i = 0; i < N; i++) pend[d][i] = 1'b0;
        end
        #2 reset = 1'b1;
        model_reset();
        #1 check_all("reset");
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < N; i++) begin
                    if (!pend[d][i]) begin
                        if ($urandom_range(0, 2) == 0) begin
                            pend[d][i] = 1'b1;
                            ireqs[d][i] = rand_req();
                        end else
                            ireqs[d][i] = '0;
                    end else if (busy[d] && owner[d] == i && $urandom_range(0, 31) == 0)
                        ireqs[d][i].valid = 1'b0;
                end
                oresp[d].data  = $urandom;
                oresp[d].ready = busy[d] ? 1'($urandom) : ($urandom_range(0, 3) == 0);
                oresp[d].last  = busy[d] ? (oresp[d].ready && beats[d] == olen[d]) : 1'($urandom);
            end
            reset = (c % 250 == 100);
            if (reset) model_reset();
            #1 check_all(reset ? "midrst" : "run");
            @(posedge clk);
            if (!reset) begin
                for (int d = 0; d < 2; d++) begin
                    if (!busy[d]) begin
                        owner[d] = pick(d);
                        if (owner[d] >= 0) begin
                            busy[d]  = 1'b1;
                            beats[d] = 0;
                            olen[d]  = int'(ireqs[d][owner[d]].len);
                        end else
                            owner[d] = 0;
                    end else if (oresp[d].ready && oresp[d].last) begin
                        busy[d] = 1'b0;
                        pend[d][owner[d]] = 1'b0;
                        next_first[d] = (owner[d] + 1) % N;
                    end else if (oresp[d].ready)
                        beats[d]++;
                end
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
